// File: rtl/seg7_mux_driver.sv
// Two-digit multiplexed seven-segment driver for an 8-bit hex value.
// Inter-digit blanking prevents ghosting; new values are committed only at frame boundaries.
module seg7_mux_driver #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter bit          LZ_BLANK     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value_in,
    input  logic       value_valid,
    output logic [6:0] seg_C,
    output logic [1:0] seg_A,
    output logic       frame_tick
);

    localparam int unsigned CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned ON_CYCLES = REFRESH_DIV - BLANK_CYCLES;

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dig_q, dig_d;
    logic [7:0]         disp_q, disp_d;
    logic [7:0]         pend_q, pend_d;
    logic               pend_flag_q, pend_flag_d;
    logic [6:0]         seg_c_q, seg_c_d;
    logic [1:0]         seg_a_q, seg_a_d;
    logic               frame_tick_q, frame_tick_d;
    logic               last_c;
    logic               boundary_c;
    logic [3:0]         nib_c;

    // Active-low gfedcba hex decode
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        hex_to_seg = 7'h7F;
        case (n)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            4'hF: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Slot sequencing, value capture/commit and registered output decode
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        dig_d        = dig_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_flag_d  = pend_flag_q;
        seg_c_d      = 7'h7F;
        seg_a_d      = 2'b11;
        nib_c        = dig_q ? disp_q[7:4] : disp_q[3:0];

        if (state_q == ST_BLANK) begin
            last_c = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
        end else begin
            last_c = (cnt_q == CNT_W'(ON_CYCLES - 1));
        end
        boundary_c   = (state_q == ST_ON) && last_c && dig_q;
        frame_tick_d = boundary_c;

        if (last_c) begin
            cnt_d = '0;
            if (state_q == ST_BLANK) begin
                state_d = ST_ON;
            end else begin
                state_d = ST_BLANK;
                dig_d   = ~dig_q;
            end
        end

        // A valid on the boundary edge bypasses the pending register
        if (boundary_c) begin
            if (value_valid) begin
                disp_d = value_in;
            end else if (pend_flag_q) begin
                disp_d = pend_q;
            end
            pend_flag_d = 1'b0;
        end else if (value_valid) begin
            pend_d      = value_in;
            pend_flag_d = 1'b1;
        end

        if (state_q == ST_ON && !(LZ_BLANK && dig_q && disp_q[7:4] == 4'h0)) begin
            seg_c_d = hex_to_seg(nib_c);
            seg_a_d = dig_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            dig_q        <= 1'b0;
            disp_q       <= 8'h00;
            pend_q       <= 8'h00;
            pend_flag_q  <= 1'b0;
            seg_c_q      <= 7'h7F;
            seg_a_q      <= 2'b11;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_flag_q  <= pend_flag_d;
            seg_c_q      <= seg_c_d;
            seg_a_q      <= seg_a_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_C      = seg_c_q;
    assign seg_A      = seg_a_q;
    assign frame_tick = frame_tick_q;

endmodule
